fp_decoder: RTL and testbench

- Sequential decoder from the lab-1 compressed floating-point format (sign S, 3-bit exponent E, 4-bit significand F) back to a 12-bit two's-complement linear value.
- Computes D = (-1)^S × F × 2^E with an iterative one-bit-per-cycle shifter, then a sign stage.
- Sits downstream of the encoder path and reconstructs the sample for checking and DAC-style playback.
- Uses valid/ready handshakes on both sides and accepts one transaction at a time.

---
 rtl/fp_decoder_pkg.sv | 16 +
 rtl/fp_decoder_if.sv | 30 +++
 rtl/fp_decoder.sv | 102 ++++++++++
 tb/tb_fp_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_decoder_pkg.sv
// Shared definitions for the compressed floating-point decoder path:
// default field widths and the controller state encoding.
package fp_pkg;

   localparam int EXP_W = 3;
   localparam int SIG_W = 4;
   localparam int OUT_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fp_decoder_if.sv
// Valid/ready bundle between the S/E/F producer, the decoder and the
// consumer of the reconstructed linear sample.
interface fp_decoder_if #(
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int SIG_W = fp_pkg::SIG_W,
   parameter int OUT_W = fp_pkg::OUT_W
);

   logic                    in_valid;
   logic                    in_ready;
   logic                    s;
   logic [EXP_W-1:0]        e;
   logic [SIG_W-1:0]        f;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] d;

   // Producer/consumer side
   modport master (
      output in_valid, s, e, f, out_ready,
      input  in_ready, out_valid, d
   );

   // Decoder side
   modport slave (
      input  in_valid, s, e, f, out_ready,
      output in_ready, out_valid, d
   );

endinterface

// File: rtl/fp_decoder.sv
// Sequential decoder: D = (-1)^S * F * 2^E, one left shift per cycle,
// followed by a conditional-negate stage. One transaction in flight.
module fp_decoder
   import fp_pkg::*;
#(
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int SIG_W = fp_pkg::SIG_W,
   parameter int OUT_W = fp_pkg::OUT_W
) (
   input  logic         clk,
   input  logic         rst,
   fp_decoder_if.slave  bus
);

   // The largest magnitude F*2^(2^EXP_W-1) plus a sign bit must fit in OUT_W.
   if (OUT_W < SIG_W + (1 << EXP_W)) begin : g_width_check
      $error("fp_decoder: OUT_W too small for SIG_W/EXP_W");
   end

   state_t                  state;
   state_t                  state_nxt;
   logic [OUT_W-1:0]        acc;
   logic [EXP_W-1:0]        cnt;
   logic                    sign;
   logic signed [OUT_W-1:0] d_r;
   logic                    out_valid_r;
   logic                    accept;

   // Conditional two's-complement negate of an unsigned magnitude.
   function automatic logic signed [OUT_W-1:0] sign_apply(
      input logic             neg,
      input logic [OUT_W-1:0] mag
   );
      logic [OUT_W-1:0] res;
      res = neg ? (~mag + OUT_W'(1)) : mag;
      return $signed(res);
   endfunction

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = out_valid_r;
   assign bus.d         = d_r;
   assign accept        = bus.in_valid && bus.in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (cnt == '0) state_nxt = SIGN;
         SIGN:    state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch fields, shift the magnitude, apply sign, hold result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         sign        <= 1'b0;
         d_r         <= '0;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign <= bus.s;
                  cnt  <= bus.e;
                  acc  <= {{(OUT_W-SIG_W){1'b0}}, bus.f};
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  acc <= acc << 1;
                  cnt <= cnt - 1'b1;
               end
            end
            SIGN: begin
               d_r         <= sign_apply(sign, acc);
               out_valid_r <= 1'b1;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_decoder.sv
// Scoreboard bench for fp_decoder: the driver pushes the arithmetic
// expectation on every accepted input, a monitor pops and compares on
// every output handshake and also watches hold/backpressure behaviour.
module tb_fp_decoder;

   typedef struct {
      logic [11:0] d;
      int          e;
      int          acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random
   exp_t q[$];

   logic        prev_vld = 1'b0;
   logic        prev_hs  = 1'b0;
   logic [11:0] prev_d   = '0;
   int          rise_cyc = 0;

   fp_decoder_if bus ();

   fp_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] ref_decode(input logic si, input int ei, input int fi);
      int v;
      v = fi * (2 ** ei);
      if (si) v = -v;
      return v[11:0];
   endfunction

   task automatic ready_drv();
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   task automatic monitor();
      exp_t x;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
         end else begin
            if (bus.out_valid) begin
               checks++;
               if (bus.in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL in_ready_busy act=%b req=0 cyc=%0d", bus.in_ready, cyc);
               end
               if (!prev_vld) begin
                  rise_cyc = cyc;
               end else if (!prev_hs) begin
                  checks++;
                  if (bus.d !== prev_d) begin
                     errors++;
                     $display("FAIL hold_d act=%h req=%h cyc=%0d", bus.d, prev_d, cyc);
                  end
               end
               if (bus.out_ready) begin
                  checks++;
                  if (q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_out act=%h req=none cyc=%0d", bus.d, cyc);
                  end else begin
                     x = q.pop_front();
                     if (bus.d !== x.d) begin
                        errors++;
                        $display("FAIL d_value act=%h req=%h e=%0d", bus.d, x.d, x.e);
                     end
                     checks++;
                     if (rise_cyc - x.acc_cyc != x.e + 2) begin
                        errors++;
                        $display("FAIL latency act=%0d req=%0d", rise_cyc - x.acc_cyc, x.e + 2);
                     end
                  end
               end
            end else begin
               if (prev_vld && !prev_hs) begin
                  checks++;
                  errors++;
                  $display("FAIL valid_dropped act=0 req=1 cyc=%0d", cyc);
               end
               if (prev_hs) begin
                  checks++;
                  if (bus.d !== prev_d) begin
                     errors++;
                     $display("FAIL d_persist act=%h req=%h", bus.d, prev_d);
                  end
               end
            end
            prev_vld = bus.out_valid;
            prev_hs  = bus.out_valid && bus.out_ready;
            prev_d   = bus.d;
         end
      end
   endtask

   task automatic send(input logic si, input logic [2:0] ei, input logic [3:0] fi);
      int   guard;
      exp_t x;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.s = si;
      bus.e = ei;
      bus.f = fi;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus.in_ready && guard < 500);
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout act=busy req=ready");
         bus.in_valid = 1'b0;
         return;
      end
      x.d = ref_decode(si, int'(ei), int'(fi));
      x.e = int'(ei);
      x.acc_cyc = cyc + 1;
      q.push_back(x);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.s = 1'($urandom);
      bus.e = 3'($urandom);
      bus.f = 4'($urandom);
   endtask

   task automatic wait_drained();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(q.size() == 0 && !bus.out_valid && bus.in_ready) && guard < 500);
      checks++;
      if (q.size() != 0 || bus.out_valid || !bus.in_ready) begin
         errors++;
         $display("FAIL drain_timeout act=pending%0d req=0", q.size());
      end
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.d !== 12'h000 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s act=v%b d%h r%b req=v0 d000 r1", tag, bus.out_valid, bus.d, bus.in_ready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.s         = 1'b0;
      bus.e         = '0;
      bus.f         = '0;
      bus.out_ready = 1'b1;
      fork
         ready_drv();
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset_state");

      // Directed cases
      rdy_mode = 0;
      send(1'b0, 3'd0, 4'b1010);
      wait_drained();
      send(1'b0, 3'd7, 4'hF);
      wait_drained();
      send(1'b1, 3'd3, 4'b1001);
      send(1'b1, 3'd7, 4'hF);
      send(1'b1, 3'd5, 4'h0);
      send(1'b0, 3'd4, 4'b0011);
      wait_drained();

      // Backpressure with an ignored input pulse while busy
      rdy_mode = 1;
      send(1'b0, 3'd2, 4'h3);
      for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.e = 3'd1;
      bus.f = 4'h1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rdy_mode = 0;
      wait_drained();
      send(1'b1, 3'd6, 4'hB);
      wait_drained();

      // Reset in the middle of the shift phase
      send(1'b0, 3'd6, 4'h5);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset_midshift");
      send(1'b0, 3'd1, 4'h5);
      wait_drained();

      // Randomized traffic with random consumer stalls
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         send(1'($urandom), 3'($urandom), 4'($urandom));
      end
      rdy_mode = 0;
      wait_drained();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
